// File: rtl/half_duplex_bus_transceiver_pkg.sv
// Shared types and constants for the half-duplex bus transceiver.
package half_duplex_bus_pkg;

  localparam int unsigned TA_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GUARD_ON,
    XFER,
    GUARD_OFF
  } state_t;

  localparam state_t RESET_STATE = IDLE;

endpackage

// File: rtl/half_duplex_bus_transceiver_if.sv
// Local handshake and arbiter/strobe signals of the transceiver; the pad-side bus stays a plain inout.
interface half_duplex_bus_transceiver_if #(
  parameter int WIDTH = 8
);
  logic             bus_oe;
  logic             bus_strobe_out;
  logic             peer_strobe;
  logic             bus_req;
  logic             bus_gnt;
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             collision;

  modport master (
    output bus_oe, bus_strobe_out, bus_req, tx_ready, rx_valid, rx_data, collision,
    input  peer_strobe, bus_gnt, tx_valid, tx_data
  );

  modport slave (
    input  bus_oe, bus_strobe_out, bus_req, tx_ready, rx_valid, rx_data, collision,
    output peer_strobe, bus_gnt, tx_valid, tx_data
  );
endinterface

// File: rtl/half_duplex_bus_transceiver_timer.sv
// Turnaround guard counter: load, count down to zero, hold at zero.
module bus_turnaround_timer
  import half_duplex_bus_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [TA_W-1:0] load_val,
  output logic            zero
);

  logic [TA_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/half_duplex_bus_transceiver.sv
// Half-duplex bus owner: arbitrated transmit with turnaround guards, strobed receive, sticky collision flag.
module half_duplex_bus_transceiver
  import half_duplex_bus_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  inout  wire  [WIDTH-1:0]              bus,
  half_duplex_bus_transceiver_if.master hb
);

  localparam logic [TA_W-1:0] GUARD_LOAD = TA_W'(TURNAROUND - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] data_q;
  logic             accept;
  logic             tmr_load;
  logic             tmr_zero;

  bus_turnaround_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (GUARD_LOAD),
    .zero     (tmr_zero)
  );

  assign hb.tx_ready = ((state == GUARD_ON) && tmr_zero && hb.bus_gnt) ||
                       ((state == XFER) && hb.bus_gnt);
  assign accept      = hb.tx_valid && hb.tx_ready;

  // bus_oe is flopped with an async clear, so the pads release the moment rst_n falls.
  assign bus = hb.bus_oe ? data_q : 'z;

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (hb.tx_valid) state_n = REQ;
      end
      REQ: begin
        if (hb.bus_gnt) begin
          state_n  = GUARD_ON;
          tmr_load = 1'b1;
        end else if (!hb.tx_valid) begin
          state_n = IDLE;
        end
      end
      GUARD_ON: begin
        if (!hb.bus_gnt) begin
          state_n = REQ;
        end else if (tmr_zero) begin
          if (hb.tx_valid) begin
            state_n = XFER;
          end else begin
            state_n  = GUARD_OFF;
            tmr_load = 1'b1;
          end
        end
      end
      XFER: begin
        if (!accept) begin
          state_n  = GUARD_OFF;
          tmr_load = 1'b1;
        end
      end
      GUARD_OFF: begin
        if (tmr_zero) state_n = IDLE;
      end
      default: state_n = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= RESET_STATE;
      hb.bus_req        <= 1'b0;
      hb.bus_oe         <= 1'b0;
      hb.bus_strobe_out <= 1'b0;
      data_q            <= '0;
    end else begin
      state             <= state_n;
      hb.bus_req        <= (state_n == REQ) || (state_n == GUARD_ON) || (state_n == XFER);
      hb.bus_oe         <= (state_n == XFER);
      hb.bus_strobe_out <= (state_n == XFER);
      if (accept) data_q <= hb.tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb.rx_valid  <= 1'b0;
      hb.rx_data   <= '0;
      hb.collision <= 1'b0;
    end else begin
      hb.rx_valid <= 1'b0;
      if (hb.peer_strobe) begin
        if ((state == IDLE) || (state == REQ)) begin
          hb.rx_valid <= 1'b1;
          hb.rx_data  <= bus;
        end else begin
          hb.collision <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_half_duplex_bus_transceiver.sv
// Bench for half_duplex_bus_transceiver: TURNAROUND=1 and TURNAROUND=3 instances against a timeline model.
module tb_half_duplex_bus_transceiver;

  localparam int TA_A = 1;
  localparam int TA_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic       peer_oe_a;
  logic [7:0] peer_d_a;
  wire  [7:0] bus_a;
  wire  [7:0] bus_b;
  assign bus_a = peer_oe_a ? peer_d_a : 'z;

  half_duplex_bus_transceiver_if #(.WIDTH(8)) ifa ();
  half_duplex_bus_transceiver_if #(.WIDTH(8)) ifb ();

  half_duplex_bus_transceiver #(.WIDTH(8), .TURNAROUND(TA_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .hb(ifa.master)
  );
  half_duplex_bus_transceiver #(.WIDTH(8), .TURNAROUND(TA_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .hb(ifb.master)
  );

  logic [7:0] wq [16];
  logic       col_exp;
  logic [7:0] rx_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transmit n words from wq with grant held high; expected activity is derived
  // from cycle offsets: request at +1, guard TA_A cycles, n beats, TA_A release cycles.
  task automatic burst_a(input int n, input int strobe_c);
    int  acc;
    bit  pend;
    acc  = 0;
    pend = 0;
    ifa.tx_valid = 1'b1;
    ifa.tx_data  = wq[0];
    for (int c = 1; c <= 2 + 2*TA_A + n; c++) begin
      @(posedge clk); #1;
      if (pend) col_exp = 1'b1;
      pend = 0;
      acc = (c > 1 + TA_A) ? c - (1 + TA_A) : 0;
      if (acc > n) acc = n;
      chk("a_bus_req", 32'(ifa.bus_req), 32'(c <= 1 + TA_A + n));
      chk("a_bus_oe", 32'(ifa.bus_oe), 32'(c >= 2 + TA_A && c <= 1 + TA_A + n));
      chk("a_strobe", 32'(ifa.bus_strobe_out), 32'(c >= 2 + TA_A && c <= 1 + TA_A + n));
      if (c >= 2 + TA_A && c <= 1 + TA_A + n)
        chk("a_bus_data", 32'(bus_a), 32'(wq[c - (2 + TA_A)]));
      chk("a_tx_ready", 32'(ifa.tx_ready), 32'(c >= 1 + TA_A && c <= 1 + TA_A + n));
      chk("a_rx_valid_tx", 32'(ifa.rx_valid), 32'(1'b0));
      chk("a_collision", 32'(ifa.collision), 32'(col_exp));
      ifa.peer_strobe = 1'b0;
      if (c == strobe_c) begin
        ifa.peer_strobe = 1'b1;
        pend = 1;
      end
      ifa.tx_valid = (acc < n);
      if (acc < n) ifa.tx_data = wq[acc];
    end
    ifa.peer_strobe = 1'b0;
  endtask

  task automatic rx_beat(input logic s, input logic [7:0] d);
    peer_oe_a       = s;
    peer_d_a        = d;
    ifa.peer_strobe = s;
    @(posedge clk); #1;
    if (s) rx_last = d;
    chk("a_rx_valid", 32'(ifa.rx_valid), 32'(s));
    chk("a_rx_data", 32'(ifa.rx_data), 32'(rx_last));
    chk("a_rx_bus_oe", 32'(ifa.bus_oe), 32'(1'b0));
    peer_oe_a       = 1'b0;
    ifa.peer_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    rst_n = 1'b0;
    peer_oe_a = 1'b0; peer_d_a = '0;
    ifa.peer_strobe = 1'b0; ifa.bus_gnt = 1'b1; ifa.tx_valid = 1'b0; ifa.tx_data = '0;
    ifb.peer_strobe = 1'b0; ifb.bus_gnt = 1'b1; ifb.tx_valid = 1'b0; ifb.tx_data = '0;
    col_exp = 1'b0;
    rx_last = '0;
    #12;
    chk("rst_a_oe", 32'(ifa.bus_oe), 0);
    chk("rst_a_req", 32'(ifa.bus_req), 0);
    chk("rst_a_strobe", 32'(ifa.bus_strobe_out), 0);
    chk("rst_a_ready", 32'(ifa.tx_ready), 0);
    chk("rst_a_rxv", 32'(ifa.rx_valid), 0);
    chk("rst_a_rxd", 32'(ifa.rx_data), 0);
    chk("rst_a_col", 32'(ifa.collision), 0);
    chk("rst_b_oe", 32'(ifb.bus_oe), 0);
    chk("rst_b_req", 32'(ifb.bus_req), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single beat, then a three-word back-to-back burst
    wq[0] = 8'hA5;
    burst_a(1, -1);
    wq[0] = 8'h01; wq[1] = 8'h02; wq[2] = 8'h03;
    burst_a(3, -1);

    // grant withdrawn after one guard cycle on the TURNAROUND=3 instance
    ifb.tx_valid = 1'b1;
    ifb.tx_data  = 8'h5A;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      chk("b_bus_req", 32'(ifb.bus_req), 32'(c <= 8));
      chk("b_bus_oe", 32'(ifb.bus_oe), 32'(c == 8));
      if (c == 8) chk("b_bus_data", 32'(bus_b), 32'h5A);
      if (c == 2) ifb.bus_gnt = 1'b0;
      if (c == 4) ifb.bus_gnt = 1'b1;
      if (c == 8) ifb.tx_valid = 1'b0;
      #1;
      chk("b_tx_ready", 32'(ifb.tx_ready), 32'(c == 7 || c == 8));
    end

    // directed receive: two strobes back to back
    rx_beat(1'b1, 8'h3C);
    rx_beat(1'b1, 8'hC3);
    rx_beat(1'b0, 8'h00);

    // randomized bursts interleaved with randomized receive traffic
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) wq[k] = 8'($urandom);
      burst_a(n, -1);
      m = int'($urandom_range(2, 6));
      for (int k = 0; k < m; k++) rx_beat(1'($urandom), 8'($urandom));
      rx_beat(1'b0, 8'h00);
    end

    // peer strobes during a transmitted beat
    chk("a_col_before", 32'(ifa.collision), 0);
    wq[0] = 8'h99;
    burst_a(1, 2 + TA_A);
    repeat (3) begin
      @(posedge clk); #1;
      chk("a_col_sticky", 32'(ifa.collision), 1);
      chk("a_col_rxv", 32'(ifa.rx_valid), 0);
    end

    // asynchronous reset while the bus is driven
    wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
    ifa.tx_valid = 1'b1;
    ifa.tx_data  = wq[0];
    for (int c = 1; c <= 2 + TA_A; c++) begin
      @(posedge clk); #1;
      if (c > 1 + TA_A) ifa.tx_data = wq[c - (1 + TA_A)];
    end
    chk("mid_oe_before", 32'(ifa.bus_oe), 1);
    chk("mid_bus_before", 32'(bus_a), 32'h11);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_oe", 32'(ifa.bus_oe), 0);
    chk("arst_req", 32'(ifa.bus_req), 0);
    chk("arst_strobe", 32'(ifa.bus_strobe_out), 0);
    chk("arst_ready", 32'(ifa.tx_ready), 0);
    chk("arst_col", 32'(ifa.collision), 0);
    chk("arst_rxd", 32'(ifa.rx_data), 0);
    col_exp = 1'b0;
    rx_last = '0;
    ifa.tx_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req", 32'(ifa.bus_req), 0);
    chk("post_rst_oe", 32'(ifa.bus_oe), 0);
    wq[0] = 8'h6E;
    burst_a(1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/half_duplex_bus_transceiver.md
Name: half_duplex_bus_transceiver

Overview:
- Clocked owner of one shared, bidirectional, half-duplex data bus.
- Transmit side: drives the bus only while granted, through an output-enable that gates the bus drivers (transmission-gate / tri-state pair on the pad side).
- Receive side: releases the bus and captures words the peer strobes onto it.
- Turnaround guard cycles separate release and drive on every direction change.
- Sits between a local valid/ready source and sink and an external bus arbiter.

Parameters:
- WIDTH, 8, bus and data width in bits.
- TURNAROUND, 1, guard cycles after grant before driving and after last beat before returning to listen; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- bus  inout  WIDTH  shared data bus; driven with the data register when bus_oe=1, otherwise high-Z.
- bus_oe  output  1  driver enable; also drives the external pass-gate control.
- bus_strobe_out  output  1  high for exactly one cycle per transmitted beat.
- peer_strobe  input  1  peer qualifies valid data on bus.
- bus_req  output  1  request to arbiter.
- bus_gnt  input  1  grant from arbiter.
- tx_valid  input  1  local word available.
- tx_data  input  WIDTH  local word.
- tx_ready  output  1  accept; a transfer occurs on an edge where tx_valid and tx_ready are both 1.
- rx_valid  output  1  one-cycle pulse, rx_data valid.
- rx_data  output  WIDTH  last received word.
- collision  output  1  sticky error flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - bus_oe, bus_req, bus_strobe_out, tx_ready, rx_valid and collision all 0.
  - rx_data=0 and the data register=0.
  - bus goes high-Z immediately, without waiting for a clock edge, including mid-transfer.
- States: IDLE, REQ, GUARD_ON, XFER, GUARD_OFF.
- Registered outputs:
  - bus_req=1 in REQ, GUARD_ON and XFER.
  - bus_oe=1 and bus_strobe_out=1 only in XFER.
- tx_ready is combinational and equals 1 when either:
  - state is GUARD_ON, the guard count is 0 and bus_gnt=1; or
  - state is XFER and bus_gnt=1.
- IDLE:
  - tx_valid=1 goes to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - bus_gnt=1 goes to GUARD_ON and loads the guard count with TURNAROUND-1.
  - tx_valid=0 returns to IDLE.
  - Otherwise stay in REQ.
- GUARD_ON:
  - Bus stays released.
  - The count decrements each cycle while nonzero.
  - bus_gnt=0 at any point returns to REQ.
  - An accept (count 0) loads tx_data into the data register and moves to XFER.
  - If the count is 0 and tx_valid=0, go to GUARD_OFF (bus never driven).
- XFER:
  - Bus shows the data register for this cycle.
  - An accept on this edge stays in XFER with the new word, giving back-to-back beats at one word per cycle.
  - With no accept (tx_valid=0 or bus_gnt=0), go to GUARD_OFF; bus_oe is 0 from the next cycle.
  - A beat already presented always completes, even if bus_gnt falls during it.
- GUARD_OFF:
  - Bus released, bus_req=0, for TURNAROUND cycles, then IDLE.
- Latency, with tx_valid rising before edge E and bus_gnt already high:
  - bus_req=1 after E.
  - GUARD_ON after E+1.
  - First beat on bus after E+1+TURNAROUND.
- Receive:
  - In IDLE or REQ, when peer_strobe=1 at an edge, capture bus into rx_data; rx_valid=1 for the following cycle only.
  - No backpressure on the receive side.
  - Back-to-back strobes give back-to-back pulses.
- Collision:
  - peer_strobe=1 in GUARD_ON, XFER or GUARD_OFF sets collision=1.
  - Cleared only by reset.
  - rx_data and rx_valid are not updated in that case.
  - Transmission continues unaffected.
- tx_data must be held stable while tx_valid=1 and no accept has occurred; if it is not, the last sampled word is sent.

Decomposition:
- Package half_duplex_bus_pkg holds:
  - the state enum type;
  - the TURNAROUND width constant (4 bits);
  - the IDLE reset state constant.
- One sub-module, bus_turnaround_timer:
  - load, decrement and zero flag;
  - shared by GUARD_ON and GUARD_OFF.
- The tri-state bus assignment stays in the top level.

Test Plan:
- Single beat, TURNAROUND=1, gnt tied high, tx_data=0xA5 with tx_valid held until accept:
  - bus_req rises on the next cycle;
  - bus=0xA5 with bus_oe=1 and bus_strobe_out=1 for exactly one cycle, 3 cycles after tx_valid;
  - then one high-Z guard cycle and back to IDLE.
- Burst 0x01,0x02,0x03 with valid held continuously:
  - three consecutive XFER cycles with those values and no gaps;
  - bus_oe low starting the cycle after 0x03.
- Grant withdrawn in GUARD_ON (TURNAROUND=3, gnt dropped after 1 guard cycle):
  - returns to REQ with bus never driven;
  - on re-grant, a full 3-cycle guard is repeated before 0x5A is driven.
- Receive: in IDLE the peer drives 0x3C with peer_strobe for 1 cycle, then 0xC3 on the next cycle:
  - rx_valid pulses on two consecutive cycles with rx_data 0x3C then 0xC3;
  - bus_oe stays 0 throughout.
- Collision: peer_strobe=1 during XFER:
  - collision goes to 1 and stays 1;
  - rx_valid stays 0;
  - the transmitted beat is unchanged.
- Reset mid-burst: rst_n driven low asynchronously between edges while bus_oe=1:
  - bus goes high-Z and all outputs go 0 immediately;
  - state is IDLE after release.
